// File: rtl/seg7_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver_pkg
//  Description : Shared glyph constants, blanking value and scan state type
//                for the multiplexed seven-segment scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_scan_driver_pkg;

    // Active-high glyphs, bit0 = segment a ... bit6 = segment g.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    // Active-low "all segments off" value driven on SEG_N.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Scan state: all-off gap, then one digit lit.
    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // Nibble to active-high glyph lookup.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = SEG_0;
            4'h1:    g = SEG_1;
            4'h2:    g = SEG_2;
            4'h3:    g = SEG_3;
            4'h4:    g = SEG_4;
            4'h5:    g = SEG_5;
            4'h6:    g = SEG_6;
            4'h7:    g = SEG_7;
            4'h8:    g = SEG_8;
            4'h9:    g = SEG_9;
            4'hA:    g = SEG_A;
            4'hB:    g = SEG_B;
            4'hC:    g = SEG_C;
            4'hD:    g = SEG_D;
            4'hE:    g = SEG_E;
            default: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver_if
//  Description : Host/display bundle of the seven-segment scan driver:
//                scan strobe, frame load handshake and display outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    disp_ce;
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    load;
    logic                    load_ack;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_end;

    // Host side: drives the strobe and frame data, observes the display.
    modport master (
        output disp_ce, data, dp, dig_en, load,
        input  load_ack, seg_n, dp_n, an_n, frame_end
    );

    // Driver side.
    modport slave (
        input  disp_ce, data, dp, dig_en, load,
        output load_ack, seg_n, dp_n, an_n, frame_end
    );
endinterface
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_hex_decode
//  Description : Combinational hex nibble to active-low segment decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);
    // Look up the lit-segment pattern and invert for the active-low pins.
    always_comb begin
        seg_n = ~hex_glyph(nibble);
    end
endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Multiplexed seven-segment scan driver. Double-buffered frame
//                (staging + shadow), one digit per slot with a blanking gap,
//                frame updates applied only at the frame boundary.
//                Optional macro SEG7_LZ_SUPPRESS_EN enables leading-zero
//                suppression on the shadow frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int BLANK_TICKS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam int                IDX_W        = $clog2(NUM_DIGITS);
    localparam int                DATA_W       = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0]  C_LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [3:0]        C_BLANK_LAST = 4'(BLANK_TICKS - 1);

    // Scan sequencer state
    scan_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [3:0]              blank_cnt_q, blank_cnt_d;

    // Frame buffers
    logic [DATA_W-1:0]       stage_data_q, stage_data_d;
    logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d;
    logic [NUM_DIGITS-1:0]   stage_en_q, stage_en_d;
    logic                    pending_q, pending_d;
    logic [DATA_W-1:0]       shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   shadow_en_q, shadow_en_d;

    // Registered outputs
    logic [6:0]              seg_n_q, seg_n_d;
    logic                    dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic                    load_ack_q, load_ack_d;
    logic                    frame_end_q, frame_end_d;

    // Display datapath
    logic                    boundary_w;
    logic [3:0]              nibble_w;
    logic [6:0]              seg_dec_n_w;
    logic [NUM_DIGITS-1:0]   lz_mask_w;
    logic [NUM_DIGITS-1:0]   en_eff_w;

    // Sequencer, load capture and frame-boundary swap
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        blank_cnt_d   = blank_cnt_q;
        stage_data_d  = stage_data_q;
        stage_dp_d    = stage_dp_q;
        stage_en_d    = stage_en_q;
        pending_d     = pending_q;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        shadow_en_d   = shadow_en_q;
        load_ack_d    = 1'b0;
        frame_end_d   = 1'b0;
        boundary_w    = 1'b0;

        // A new request always overwrites staging; the latest one wins.
        if (bus.load) begin
            stage_data_d = bus.data;
            stage_dp_d   = bus.dp;
            stage_en_d   = bus.dig_en;
            pending_d    = 1'b1;
        end

        if (bus.disp_ce) begin
            case (state_q)
                BLANK: begin
                    if (blank_cnt_q == C_BLANK_LAST) begin
                        state_d     = SHOW;
                        blank_cnt_d = 4'd0;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = BLANK;
                    if (idx_q == C_LAST_IDX) begin
                        idx_d      = '0;
                        boundary_w = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            endcase
        end

        // Frame swap: a same-cycle request goes straight to the shadow,
        // otherwise pending staging data is promoted. One ACK either way.
        if (boundary_w) begin
            frame_end_d = 1'b1;
            if (bus.load) begin
                shadow_data_d = bus.data;
                shadow_dp_d   = bus.dp;
                shadow_en_d   = bus.dig_en;
                pending_d     = 1'b0;
                load_ack_d    = 1'b1;
            end else if (pending_q) begin
                shadow_data_d = stage_data_q;
                shadow_dp_d   = stage_dp_q;
                shadow_en_d   = stage_en_q;
                pending_d     = 1'b0;
                load_ack_d    = 1'b1;
            end
        end
    end

`ifdef SEG7_LZ_SUPPRESS_EN
    // Mask every digit whose nibble and all higher nibbles are zero; digit 0
    // is never masked so a zero value still shows a single "0".
    always_comb begin
        logic zero_above;
        lz_mask_w  = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above   = zero_above & (shadow_data_d[4*i +: 4] == 4'h0);
            lz_mask_w[i] = zero_above;
        end
    end
`else
    // Every enabled digit is shown, including leading zeros.
    assign lz_mask_w = '0;
`endif

    assign en_eff_w = shadow_en_d & ~lz_mask_w;
    assign nibble_w = shadow_data_d[{idx_d, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .nibble (nibble_w),
        .seg_n  (seg_dec_n_w)
    );

    // Output values are derived from next-state so they appear one clock
    // after the CE that caused the change.
    always_comb begin
        seg_n_d = SEG_BLANK;
        dp_n_d  = 1'b1;
        an_n_d  = '1;
        if ((state_d == SHOW) && en_eff_w[idx_d]) begin
            an_n_d[idx_d] = 1'b0;
            seg_n_d       = seg_dec_n_w;
            dp_n_d        = ~shadow_dp_d[idx_d];
        end
    end

    // Sequencer and frame buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BLANK;
            idx_q         <= '0;
            blank_cnt_q   <= 4'd0;
            stage_data_q  <= '0;
            stage_dp_q    <= '0;
            stage_en_q    <= '0;
            pending_q     <= 1'b0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            shadow_en_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            blank_cnt_q   <= blank_cnt_d;
            stage_data_q  <= stage_data_d;
            stage_dp_q    <= stage_dp_d;
            stage_en_q    <= stage_en_d;
            pending_q     <= pending_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            shadow_en_q   <= shadow_en_d;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n_q     <= SEG_BLANK;
            dp_n_q      <= 1'b1;
            an_n_q      <= '1;
            load_ack_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            seg_n_q     <= seg_n_d;
            dp_n_q      <= dp_n_d;
            an_n_q      <= an_n_d;
            load_ack_q  <= load_ack_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign bus.seg_n     = seg_n_q;
    assign bus.dp_n      = dp_n_q;
    assign bus.an_n      = an_n_q;
    assign bus.load_ack  = load_ack_q;
    assign bus.frame_end = frame_end_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver, NUM_DIGITS = 4,
//                BLANK_TICKS = 1, DISP_CE every 4 clocks plus a continuous-CE
//                run. Leading-zero expectations follow SEG7_LZ_SUPPRESS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    logic clk;
    logic rst_n;

    seg7_scan_driver_if #(.NUM_DIGITS(4)) bus_if ();

    seg7_scan_driver #(
        .NUM_DIGITS  (4),
        .BLANK_TICKS (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ld;
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_dpn;
        logic        exp_fe;
        logic        exp_ack;
    } vec_t;

    vec_t vecs [48];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock with the given strobe/load values, then sample after the edge.
    task automatic step(input logic ce, input logic ld);
        bus_if.disp_ce = ce;
        bus_if.load    = ld;
        @(posedge clk);
        #1;
        bus_if.disp_ce = 1'b0;
        bus_if.load    = 1'b0;
    endtask

    // Eight CE slots of one frame: even slots light digit k/2, odd slots blank,
    // the last slot is the boundary. segs = {d3,d2,d1,d0} expected SEG_N.
    task automatic add_frame(input int f, input logic [27:0] segs, input logic [3:0] lit,
                             input logic [3:0] dpn, input logic ack_end);
        for (int k = 0; k < 8; k++) begin
            int e;
            int d;
            e = f * 8 + k;
            d = k / 2;
            vecs[e].ld   = 1'b0;
            vecs[e].data = 16'h0;
            vecs[e].dp   = 4'h0;
            vecs[e].en   = 4'h0;
            if ((k % 2) == 0) begin
                vecs[e].exp_an  = lit[d] ? (4'hF ^ (4'h1 << d)) : 4'hF;
                vecs[e].exp_seg = segs[7*d +: 7];
                vecs[e].exp_dpn = dpn[d];
            end else begin
                vecs[e].exp_an  = 4'hF;
                vecs[e].exp_seg = 7'h7F;
                vecs[e].exp_dpn = 1'b1;
            end
            vecs[e].exp_fe  = (k == 7);
            vecs[e].exp_ack = (k == 7) && ack_end;
        end
    endtask

    task automatic set_load(input int e, input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        vecs[e].ld   = 1'b1;
        vecs[e].data = d;
        vecs[e].dp   = dp;
        vecs[e].en   = en;
    endtask

    task automatic idle3();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] lz_an [4];
        logic [6:0] lz_seg [4];
        int fe_first;
        int fe_second;
        int multi_low;

        rst_n          = 1'b0;
        bus_if.disp_ce = 1'b0;
        bus_if.load    = 1'b0;
        bus_if.data    = '0;
        bus_if.dp      = '0;
        bus_if.dig_en  = '0;

        // ---------------- Vector table ----------------
        add_frame(0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b0000, 4'b1111, 1'b1);
        set_load(0, 16'h1234, 4'h0, 4'hF);
        add_frame(1, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 4'b1111, 1'b0);
        add_frame(2, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 4'b1111, 1'b1);
        set_load(16, 16'h1111, 4'h0, 4'hF);
        set_load(18, 16'h2222, 4'h0, 4'hF);
        add_frame(3, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111, 4'b1111, 1'b1);
        set_load(31, 16'h5A3E, 4'b0001, 4'b0101);
        add_frame(4, {7'h7F, 7'h08, 7'h7F, 7'h06}, 4'b0101, 4'b1110, 1'b1);
        set_load(33, 16'hF9C7, 4'b1010, 4'hF);
        add_frame(5, {7'h0E, 7'h10, 7'h46, 7'h78}, 4'b1111, 4'b0101, 1'b0);

        // ---------------- Reset with CE toggling ----------------
        for (int i = 0; i < 4; i++) begin
            step(i[0], 1'b0);
            chk("rst_seg_n", 32'(bus_if.seg_n), 32'h7F);
            chk("rst_an_n", 32'(bus_if.an_n), 32'hF);
            chk("rst_dp_n", 32'(bus_if.dp_n), 32'h1);
            chk("rst_ack", 32'(bus_if.load_ack), 32'h0);
            chk("rst_fe", 32'(bus_if.frame_end), 32'h0);
        end
        rst_n = 1'b1;

        // ---------------- Table-driven frames ----------------
        for (int i = 0; i < 48; i++) begin
            if (vecs[i].ld) begin
                bus_if.data   = vecs[i].data;
                bus_if.dp     = vecs[i].dp;
                bus_if.dig_en = vecs[i].en;
            end
            step(1'b1, vecs[i].ld);
            chk($sformatf("v%0d_an_n", i), 32'(bus_if.an_n), 32'(vecs[i].exp_an));
            chk($sformatf("v%0d_seg_n", i), 32'(bus_if.seg_n), 32'(vecs[i].exp_seg));
            chk($sformatf("v%0d_dp_n", i), 32'(bus_if.dp_n), 32'(vecs[i].exp_dpn));
            chk($sformatf("v%0d_frame_end", i), 32'(bus_if.frame_end), 32'(vecs[i].exp_fe));
            chk($sformatf("v%0d_load_ack", i), 32'(bus_if.load_ack), 32'(vecs[i].exp_ack));
            step(1'b0, 1'b0);
            chk($sformatf("v%0d_fe_pulse", i), 32'(bus_if.frame_end), 32'h0);
            chk($sformatf("v%0d_ack_pulse", i), 32'(bus_if.load_ack), 32'h0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
        end

        // ---------------- Reset mid-SHOW drops pending load ----------------
        step(1'b1, 1'b0);
        chk("mid_show_an_n", 32'(bus_if.an_n), 32'hE);
        bus_if.data   = 16'h8888;
        bus_if.dp     = 4'hF;
        bus_if.dig_en = 4'hF;
        step(1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_an_n", 32'(bus_if.an_n), 32'hF);
        chk("async_rst_seg_n", 32'(bus_if.seg_n), 32'h7F);
        chk("async_rst_dp_n", 32'(bus_if.dp_n), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0);
            chk($sformatf("post_rst%0d_an_n", k), 32'(bus_if.an_n), 32'hF);
            if (k == 7) begin
                chk("post_rst_frame_end", 32'(bus_if.frame_end), 32'h1);
                chk("post_rst_no_ack", 32'(bus_if.load_ack), 32'h0);
            end
            idle3();
        end

        // ---------------- Leading zeros (DATA = 0070) ----------------
        bus_if.data   = 16'h0070;
        bus_if.dp     = 4'h0;
        bus_if.dig_en = 4'hF;
        step(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0);
            if (k == 7) chk("lz_load_ack", 32'(bus_if.load_ack), 32'h1);
            idle3();
        end
        lz_an[0] = 4'hE; lz_seg[0] = 7'h40;
        lz_an[1] = 4'hD; lz_seg[1] = 7'h78;
`ifdef SEG7_LZ_SUPPRESS_EN
        lz_an[2] = 4'hF; lz_seg[2] = 7'h7F;
        lz_an[3] = 4'hF; lz_seg[3] = 7'h7F;
`else
        lz_an[2] = 4'hB; lz_seg[2] = 7'h40;
        lz_an[3] = 4'h7; lz_seg[3] = 7'h40;
`endif
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0);
            if ((k % 2) == 0) begin
                chk($sformatf("lz_d%0d_an_n", k / 2), 32'(bus_if.an_n), 32'(lz_an[k/2]));
                chk($sformatf("lz_d%0d_seg_n", k / 2), 32'(bus_if.seg_n), 32'(lz_seg[k/2]));
            end
            idle3();
        end

        // ---------------- Continuous DISP_CE ----------------
        fe_first  = -1;
        fe_second = -1;
        multi_low = 0;
        bus_if.disp_ce = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk);
            #1;
            if ($countones(~bus_if.an_n) > 1) multi_low++;
            if (bus_if.frame_end) begin
                if (fe_first < 0) fe_first = c;
                else if (fe_second < 0) fe_second = c;
            end
        end
        bus_if.disp_ce = 1'b0;
        chk("cont_ce_first_fe", 32'(fe_first), 32'd8);
        chk("cont_ce_frame_len", 32'(fe_second - fe_first), 32'd8);
        chk("cont_ce_one_anode", 32'(multi_low), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
